// File: rtl/alu_pkg.sv
// Shared control codes, FSM states and combinational ALU evaluation.
// State MUL exists only when ALU_MULTICYCLE_MUL_EN is defined.
package alu_pkg;

  localparam logic [2:0] CTL_AND  = 3'b000;
  localparam logic [2:0] CTL_XOR  = 3'b001;
  localparam logic [2:0] CTL_SLL  = 3'b010;
  localparam logic [2:0] CTL_ADD  = 3'b011;
  localparam logic [2:0] CTL_SUB  = 3'b100;
  localparam logic [2:0] CTL_MUL  = 3'b101;
  localparam logic [2:0] CTL_SRAI = 3'b110;
  localparam logic [2:0] CTL_ILL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MULTICYCLE_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        illegal;
  } alu_res_t;

  // mul is handled by the sequencer; here it falls to the illegal default
  function automatic alu_res_t alu_eval(
    input logic [2:0]  ctl,
    input logic [31:0] a,
    input logic [31:0] b
  );
    alu_res_t r;
    r.data    = '0;
    r.illegal = 1'b0;
    unique case (ctl)
      CTL_AND:  r.data = a & b;
      CTL_XOR:  r.data = a ^ b;
      CTL_SLL:  r.data = a << b[4:0];
      CTL_ADD:  r.data = a + b;
      CTL_SUB:  r.data = a - b;
      CTL_SRAI: r.data = $unsigned($signed(a) >>> b[4:0]);
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier datapath, low 32 bits of the product.
// product already includes the partial term of the current step.
module alu_mul_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] product
);

  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;

  assign product = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= multiplicand;
      mplier_q <= multiplier;
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops, 32-cycle sequential mul.
// Multiplier is built only when ALU_MULTICYCLE_MUL_EN is defined.
module alu_multicycle
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  ctl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        accept_i,
  output logic [31:0] data_o,
  output logic        illegal_o
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] data_q;
  logic        ill_q;
  alu_res_t    res;
  logic        go;
  logic        mul_go;
  logic        mul_last;
  logic [31:0] mul_prod;

  assign res       = alu_eval(ctl_i, data1_i, data2_i);
  assign go        = start_i && (state_q == S_IDLE);
  assign ready_o   = (state_q == S_IDLE);
  assign valid_o   = (state_q == S_DONE);
  assign data_o    = data_q;
  assign illegal_o = ill_q;

`ifdef ALU_MULTICYCLE_MUL_EN
  logic [4:0] cnt_q;

  assign mul_go   = go && (ctl_i == CTL_MUL);
  assign mul_last = (state_q == S_MUL) && (cnt_q == 5'd31);

  alu_mul_seq u_mul (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load         (mul_go),
    .step         (state_q == S_MUL),
    .multiplicand (data1_i),
    .multiplier   (data2_i),
    .product      (mul_prod)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      cnt_q <= '0;
    else if (mul_go)
      cnt_q <= '0;
    else if (state_q == S_MUL)
      cnt_q <= cnt_q + 5'd1;
  end
`else
  assign mul_go   = 1'b0;
  assign mul_last = 1'b0;
  assign mul_prod = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
`ifdef ALU_MULTICYCLE_MUL_EN
          state_d = mul_go ? S_MUL : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU_MULTICYCLE_MUL_EN
      S_MUL:
        if (mul_last) state_d = S_DONE;
`endif
      S_DONE:
        if (accept_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // result registers only load on entry to DONE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
      ill_q  <= 1'b0;
    end else if (go && !mul_go) begin
      data_q <= res.data;
      ill_q  <= res.illegal;
    end else if (mul_last) begin
      data_q <= mul_prod;
      ill_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: transaction model plus
// directed literal checks and randomized operations.
module tb_alu_multicycle;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  ctl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        ready_o;
  logic        valid_o;
  logic        accept_i;
  logic [31:0] data_o;
  logic        illegal_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

`ifdef ALU_MULTICYCLE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_multicycle dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ctl_i     (ctl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .accept_i  (accept_i),
    .data_o    (data_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_ill(input logic [2:0] c);
    return (c == 3'd7) || (c == 3'd5 && !MUL_EN);
  endfunction

  function automatic int ref_lat(input logic [2:0] c);
    return (c == 3'd5 && MUL_EN) ? 32 : 1;
  endfunction

  function automatic logic [31:0] ref_data(input logic [2:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a ^ b;
      3'd2: r = a << b[4:0];
      3'd3: r = a + b;
      3'd4: r = a - b;
      3'd5: r = MUL_EN ? a * b : 32'd0;
      3'd6: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // transaction-level model: busy/valid plus edges left to result
  bit          m_busy;
  bit          m_valid;
  int          m_left;
  logic [31:0] m_pres;
  bit          m_pill;
  logic [31:0] m_data;
  bit          m_ill;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_data  <= '0;
      m_ill   <= 1'b0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_busy <= 1'b1;
        m_pres <= ref_data(ctl_i, data1_i, data2_i);
        m_pill <= ref_ill(ctl_i);
        if (ref_lat(ctl_i) == 1) begin
          m_valid <= 1'b1;
          m_data  <= ref_data(ctl_i, data1_i, data2_i);
          m_ill   <= ref_ill(ctl_i);
        end else begin
          m_left <= ref_lat(ctl_i);
        end
      end
    end else if (m_valid) begin
      if (accept_i) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_data  <= m_pres;
        m_ill   <= m_pill;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("mdl_ready", 32'(ready_o), 32'(!m_busy));
      chk("mdl_valid", 32'(valid_o), 32'(m_valid));
      chk("mdl_data", data_o, m_data);
      chk("mdl_ill", 32'(illegal_o), 32'(m_ill));
    end
  end

  // called at a negedge while idle; returns at a negedge while idle
  task automatic op(input string nm, input logic [2:0] c,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_d, input bit exp_il,
                    input int exp_lat, input int hold);
    int n;
    start_i  = 1'b1;
    ctl_i    = c;
    data1_i  = a;
    data2_i  = b;
    accept_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (!valid_o && n < 40) begin
      start_i = 1'($urandom);
      ctl_i   = 3'($urandom);
      data1_i = $urandom;
      data2_i = $urandom;
      @(negedge clk_i);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_data"}, data_o, exp_d);
    chk({nm, "_ill"}, 32'(illegal_o), 32'(exp_il));
    for (int i = 0; i < hold; i++) begin
      start_i = 1'($urandom);
      data1_i = $urandom;
      @(negedge clk_i);
      chk({nm, "_hold_d"}, data_o, exp_d);
      chk({nm, "_hold_v"}, 32'(valid_o), 32'd1);
      chk({nm, "_hold_r"}, 32'(ready_o), 32'd0);
    end
    accept_i = 1'b1;
    start_i  = 1'b1;
    ctl_i    = 3'($urandom);
    @(negedge clk_i);
    accept_i = 1'b0;
    start_i  = 1'b0;
    chk({nm, "_rdy"}, 32'(ready_o), 32'd1);
    chk({nm, "_vclr"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    rst_i    = 1'b0;
    start_i  = 1'b0;
    ctl_i    = 3'd0;
    data1_i  = '0;
    data2_i  = '0;
    accept_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    rst_i  = 1'b1;
    chk_on = 1'b1;

    op("add", 3'd3, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1, 0);
    op("sub", 3'd4, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1, 1);
    op("srai", 3'd6, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1, 0);
    op("sll", 3'd2, 32'd1, 32'd31, 32'h80000000, 1'b0, 1, 0);
    if (MUL_EN)
      op("mul", 3'd5, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 32, 0);
    else
      op("mul_off", 3'd5, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b1, 1, 0);
    op("bp", 3'd1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 1'b0, 1, 5);
    op("ill", 3'd7, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b1, 1, 0);
    op("ill_clr", 3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000,
       1'b0, 1, 0);

    // abort mid-operation: counter 10 in MUL, or a pending DONE
    start_i = 1'b1;
    ctl_i   = 3'd5;
    data1_i = 32'h00012345;
    data2_i = 32'h00000777;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_data", data_o, 32'd0);
    chk("arst_ill", 32'(illegal_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    op("post_rst", 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,
       1'b0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      c = 3'($urandom);
      a = $urandom;
      b = $urandom;
      if (k % 4 == 0) b = 32'($urandom_range(0, 40));
      op("rnd", c, a, b, ref_data(c, a, b), ref_ill(c), ref_lat(c),
         $urandom_range(0, 3));
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have ports: clk_i  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: start_i  input  1  operation request; accepted when start_i && ready_o at a rising edge.
REQ-004 SHALL have: ctl_i  input  3  ALU control code: and 000, xor 001, sll 010, add 011, sub 100, mul 101, srai 110, 111 illegal.
REQ-005 SHALL have: data1_i  input  32  operand A; data2_i  input  32  operand B; shift amount is data2_i[4:0].
REQ-006 SHALL have: ready_o  output  1  high only in IDLE.
REQ-007 SHALL have: valid_o  output  1  result available, held until consumed.
REQ-008 SHALL have: accept_i  input  1  consumer takes the result when valid_o && accept_i.
REQ-009 SHALL have: data_o  output  32  result; illegal_o  output  1  flag for an unsupported ctl code, valid with valid_o.

Function
REQ-010 SHALL implement states IDLE, MUL, DONE.
REQ-011 SHALL, on accept in IDLE, register ctl_i, data1_i and data2_i; later input changes SHALL NOT affect the result.
REQ-012 SHALL, for non-mul codes, compute in the accept edge and enter DONE, so valid_o rises 1 cycle after accept.
REQ-013 SHALL compute and, xor, add and sub modulo 2^32 with no overflow flag; sll is logical left by data2_i[4:0]; srai is arithmetic right by data2_i[4:0].
REQ-014 SHALL, for mul, enter MUL and run a radix-2 shift-add over 32 edges with a 5-bit counter from 0 to 31; the edge with counter 31 enters DONE, so valid_o rises 32 cycles after accept; data_o = low 32 bits of the unsigned product.
REQ-015 SHALL, for code 111, return data_o=0 and illegal_o=1 with single-cycle latency.
REQ-016 SHALL hold data_o, illegal_o and valid_o stable in DONE until accept_i is high; on that edge it SHALL go to IDLE and clear valid_o.
REQ-017 SHALL ignore start_i while not in IDLE, including in the same cycle as the DONE accept edge; there is no back-to-back overlap.
REQ-018 SHALL keep data_o at its last value in IDLE and MUL; it changes only on entry to DONE.

Reset
REQ-019 SHALL, while rst_i=0 and independent of clk_i, force: state IDLE, ready_o=1, valid_o=0, data_o=0, illegal_o=0, counter=0, multiplier accumulator=0.
REQ-020 SHALL abort any in-flight MUL or pending DONE on reset, producing no result; the first edge after release SHALL be able to accept a new operation.

Configuration
REQ-021 SHALL compile the multiplier only when macro ALU_MULTICYCLE_MUL_EN is defined.
REQ-022 SHALL, with ALU_MULTICYCLE_MUL_EN defined, follow REQ-014; without it, the MUL state and multiplier logic SHALL be absent and code 101 SHALL behave as code 111 (data_o=0, illegal_o=1, 1-cycle latency).

Structure
REQ-023 SHALL take the 3-bit control-code constants and the state enumeration from shared package alu_pkg; the control-code decoder SHALL use the same package.
REQ-024 SHALL place the shift-add datapath in sub-module alu_mul_seq (ports: load, step, multiplicand, multiplier, product), instantiated only under ALU_MULTICYCLE_MUL_EN.

Verification
REQ-025 SHALL test add: data1=0x7FFFFFFF, data2=1, ctl=011 -> data_o=0x80000000, illegal_o=0, valid_o 1 cycle after accept.
REQ-026 SHALL test sub and shifts: sub 5-7 -> 0xFFFFFFFE; srai 0x80000000 by 4 -> 0xF8000000; sll 1 by 31 -> 0x80000000.
REQ-027 SHALL test mul: 0xFFFFFFFF*3 -> 0xFFFFFFFD exactly 32 cycles after accept; start_i pulses and operand changes during MUL are ignored. Without the macro -> data_o=0, illegal_o=1 after 1 cycle.
REQ-028 SHALL test back-pressure: accept_i low for 5 cycles in DONE -> data_o/valid_o stable, ready_o=0; accept on 6th -> ready_o=1 next cycle.
REQ-029 SHALL test reset mid-MUL: rst_i=0 at counter 10 -> immediately valid_o=0, ready_o=1, data_o=0; a following and 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
REQ-030 SHALL test the illegal code: ctl=111 with any operands -> data_o=0, illegal_o=1; illegal_o clears on the next legal result.
